prog_loader: RTL and testbench

- Host-side program loader: the writer end of the 14-bit instruction/data memory that the CPU core reads.
- Accepts a stream of 14-bit words over a valid/ready handshake and writes them to consecutive addresses from 0 through the memory write port.
- Reads the image back, verifies it against a running checksum, and holds the CPU in reset until the load has verified.
- Sits between the external host interface and the memory's enable/address/data-in/data-out ports.

---
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_loader.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: host-side program loader for the CPU's 14-bit instruction/data memory.
//
// It accepts a stream of words over a valid/ready handshake and writes them to
// consecutive addresses starting at 0. It then reads the image back and compares
// the sum of the read data against a running checksum of the accepted words.
// The CPU is held in reset until a load has been verified.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   start, len            begin a load of len words (valid range 1..DEPTH)
//   in_data, in_valid     host word stream
//   in_ready              loader accepts a word this cycle
//   mem_en, mem_add       memory write enable / address (address also drives reads)
//   mem_datain            memory write data
//   mem_dataout           memory read data (synchronous read, one cycle latency)
//   cpu_hold              1 = CPU fsm and PC held
//   busy, done, err       load/verify status
//   checksum              sum of accepted words mod 2^DATA_W
module prog_loader #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_add,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = 1;
  localparam logic [ADDR_W+1:0] TWO_V   = 2;

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  state_t            state, state_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic [ADDR_W-1:0] wr_cnt, wr_cnt_n;
  logic [ADDR_W+1:0] vcnt, vcnt_n;
  logic [DATA_W-1:0] vsum, vsum_n;
  logic [DATA_W-1:0] checksum_n, mem_datain_n;
  logic [ADDR_W-1:0] mem_add_n;
  logic              in_ready_n, mem_en_n, cpu_hold_n, busy_n, done_n, err_n;

  logic              xfer, bad_len, rd_window, vfinish;
  logic [ADDR_W:0]   last_idx;
  logic [ADDR_W+1:0] len_ext, vlim;

  assign xfer     = (state == LOAD) && in_valid && in_ready;
  assign bad_len  = (len == '0) || (len > LEN_MAX);
  assign last_idx = len_q - ONE_L;
  assign len_ext  = {1'b0, len_q};
  assign vlim     = len_ext + TWO_V;
  // vcnt counts VERIFY edges after the last accept. Address i goes out when
  // vcnt==i, the memory registers it one edge later, so its data is summed
  // when vcnt==i+2. The final compare happens one edge after the last sample.
  assign rd_window = (vcnt >= TWO_V) && (vcnt < vlim);
  assign vfinish   = (vcnt == vlim);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n      = state;
    len_n        = len_q;
    wr_cnt_n     = wr_cnt;
    vcnt_n       = vcnt;
    vsum_n       = vsum;
    checksum_n   = checksum;
    mem_datain_n = mem_datain;
    mem_add_n    = mem_add;
    in_ready_n   = in_ready;
    mem_en_n     = 1'b0;
    cpu_hold_n   = cpu_hold;
    busy_n       = busy;
    done_n       = done;
    err_n        = err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          if (bad_len) begin
            state_n    = DONE;
            done_n     = 1'b1;
            err_n      = 1'b1;
            busy_n     = 1'b0;
            cpu_hold_n = 1'b1;
            in_ready_n = 1'b0;
          end else begin
            state_n    = LOAD;
            len_n      = len;
            wr_cnt_n   = '0;
            checksum_n = '0;
            busy_n     = 1'b1;
            done_n     = 1'b0;
            err_n      = 1'b0;
            cpu_hold_n = 1'b1;
            in_ready_n = 1'b1;
          end
        end
      end
      LOAD: begin
        if (xfer) begin
          mem_en_n     = 1'b1;
          mem_add_n    = wr_cnt;
          mem_datain_n = in_data;
          checksum_n   = add_mod(checksum, in_data);
          if ({1'b0, wr_cnt} == last_idx) begin
            in_ready_n = 1'b0;
            state_n    = VERIFY;
            vcnt_n     = '0;
            vsum_n     = '0;
          end else begin
            wr_cnt_n = wr_cnt + 1'b1;
          end
        end
      end
      VERIFY: begin
        vcnt_n = vcnt + 1'b1;
        if (vcnt < len_ext) mem_add_n = vcnt[ADDR_W-1:0];
        if (rd_window) vsum_n = add_mod(vsum, mem_dataout);
        if (vfinish) begin
          state_n    = DONE;
          busy_n     = 1'b0;
          done_n     = 1'b1;
          err_n      = (vsum != checksum);
          cpu_hold_n = (vsum != checksum);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      wr_cnt     <= '0;
      vcnt       <= '0;
      vsum       <= '0;
      checksum   <= '0;
      mem_datain <= '0;
      mem_add    <= '0;
      in_ready   <= 1'b0;
      mem_en     <= 1'b0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      len_q      <= len_n;
      wr_cnt     <= wr_cnt_n;
      vcnt       <= vcnt_n;
      vsum       <= vsum_n;
      checksum   <= checksum_n;
      mem_datain <= mem_datain_n;
      mem_add    <= mem_add_n;
      in_ready   <= in_ready_n;
      mem_en     <= mem_en_n;
      cpu_hold   <= cpu_hold_n;
      busy       <= busy_n;
      done       <= done_n;
      err        <= err_n;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Testbench for prog_loader: drives host word streams into the loader, models
// the synchronous-read memory, and checks every cycle against a transaction-level
// reference model, plus literal expectations for the directed scenarios.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  len;
  logic [13:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_en;
  logic [4:0]  mem_add;
  logic [13:0] mem_datain;
  logic [13:0] mem_dataout;
  logic        cpu_hold, busy, done, err;
  logic [13:0] checksum;

  prog_loader #(.DATA_W(14), .ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_en(mem_en), .mem_add(mem_add), .mem_datain(mem_datain),
    .mem_dataout(mem_dataout), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .err(err), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory (synchronous read) ----------------
  logic [13:0] mem [32];
  bit          corrupt = 1'b0;
  int          n_wr = 0;

  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      mem[mem_add] <= mem_datain;
      n_wr++;
    end
    mem_dataout <= (corrupt && mem_add == 5'd1) ? 14'h0 : mem[mem_add];
  end

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 load, 2 verify, 3 done
  int          m_phase = 0;
  int          m_len = 0;
  int          m_cnt = 0;
  int          m_d = 0;
  logic [13:0] m_words [32];
  logic [13:0] m_sum = '0;
  logic [13:0] m_din = '0;
  logic [4:0]  m_add = '0;
  bit m_ready = 0, m_en = 0, m_busy = 0, m_done = 0, m_err = 0, m_hold = 1;
  bit m_add_vld = 1, m_din_vld = 1;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ready = 0; m_en = 0; m_add = '0; m_din = '0;
      m_busy = 0; m_done = 0; m_err = 0; m_hold = 1; m_sum = '0;
      m_add_vld = 1; m_din_vld = 1;
    end else begin
      m_en = 0; m_add_vld = 0; m_din_vld = 0;
      case (m_phase)
        0, 3: if (start) begin
          if (len == 0 || len > 32) begin
            m_phase = 3; m_done = 1; m_err = 1; m_busy = 0; m_hold = 1; m_ready = 0;
          end else begin
            m_phase = 1; m_len = int'(len); m_cnt = 0; m_sum = '0;
            m_ready = 1; m_busy = 1; m_done = 0; m_err = 0; m_hold = 1;
          end
        end
        1: if (in_valid && m_ready) begin
          m_words[m_cnt] = in_data;
          m_en = 1; m_add = 5'(m_cnt); m_din = in_data;
          m_add_vld = 1; m_din_vld = 1;
          m_sum = m_sum + in_data;
          m_cnt++;
          if (m_cnt == m_len) begin
            m_ready = 0; m_phase = 2; m_d = 0;
          end
        end
        2: begin
          logic [13:0] rb;
          m_d++;
          // read address i is on the bus after the (i+1)-th edge past the last accept
          m_add = 5'((m_d - 1 < m_len) ? m_d - 1 : m_len - 1);
          m_add_vld = 1;
          if (m_d == m_len + 3) begin
            rb = '0;
            for (int i = 0; i < m_len; i++)
              rb = rb + ((corrupt && i == 1) ? 14'h0 : m_words[i]);
            m_phase = 3; m_busy = 0; m_done = 1;
            m_err = (rb != m_sum); m_hold = m_err;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(m_ready));
      check("mem_en",   32'(mem_en),   32'(m_en));
      check("busy",     32'(busy),     32'(m_busy));
      check("done",     32'(done),     32'(m_done));
      check("err",      32'(err),      32'(m_err));
      check("cpu_hold", 32'(cpu_hold), 32'(m_hold));
      check("checksum", 32'(checksum), 32'(m_sum));
      if (m_add_vld) check("mem_add",    32'(mem_add),    32'(m_add));
      if (m_din_vld) check("mem_datain", 32'(mem_datain), 32'(m_din));
    end
  end

  // ---------------- host driver ----------------
  logic [13:0] src [64];
  int src_n = 0, idx = 0, vmode = 0, pcnt = 0;
  int cyc = 0, n_acc = 0, last_acc = 0;
  bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  task automatic drive();
    bit v;
    case (vmode)
      0:       v = 1;
      1:       v = pat[pcnt % 7];
      default: v = 1'($urandom_range(0, 1));
    endcase
    in_valid = v && (idx < src_n);
    in_data  = in_valid ? src[idx] : 14'($urandom);
    pcnt++;
  endtask

  task automatic step();
    bit xf;
    @(negedge clk);
    xf = in_valid && in_ready;
    @(posedge clk);
    cyc++;
    if (xf) begin idx++; n_acc++; last_acc = cyc; end
    #1;
    drive();
  endtask

  task automatic do_start(input int l);
    start = 1; len = 6'(l); in_valid = 0; pcnt = 0; idx = 0;
    step();
    start = 0;
  endtask

  task automatic wait_done(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1 && busy === 1'b0) begin ok = 1; break; end
      step();
    end
    if (!ok) check("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic set_words(input int n);
    for (int i = 0; i < 64; i++) src[i] = 14'($urandom);
    src_n = n;
  endtask

  int w0, a0;
  logic [13:0] cs_prev;

  initial begin
    rst = 1; start = 0; len = '0; in_valid = 0; in_data = '0;
    @(posedge clk); #1;
    chk_en = 1;
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_en",   32'(mem_en),   32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done",     32'(done),     32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    rst = 0;
    step();

    // basic load
    src[0] = 14'h1234; src[1] = 14'h0F0F; src[2] = 14'h3FFF; src_n = 3;
    vmode = 0; w0 = n_wr;
    do_start(3);
    wait_done(100);
    check("basic_checksum", 32'(checksum), 32'h2142);
    check("basic_latency",  32'(cyc - last_acc), 32'd6);
    check("basic_err",      32'(err), 32'd0);
    check("basic_hold",     32'(cpu_hold), 32'd0);
    check("basic_writes",   32'(n_wr - w0), 32'd3);
    check("basic_mem1",     32'(mem[1]), 32'h0F0F);
    check("basic_mem2",     32'(mem[2]), 32'h3FFF);

    // backpressure
    set_words(4); vmode = 1; w0 = n_wr; a0 = n_acc;
    do_start(4);
    wait_done(100);
    check("bp_writes", 32'(n_wr - w0), 32'd4);
    check("bp_accepts", 32'(n_acc - a0), 32'd4);
    check("bp_mem3", 32'(mem[3]), 32'(src[3]));
    check("bp_err", 32'(err), 32'd0);

    // verify mismatch
    src[0] = 14'h1234; src[1] = 14'h0F0F; src[2] = 14'h3FFF; src_n = 3;
    vmode = 0; corrupt = 1;
    do_start(3);
    wait_done(100);
    check("mm_done", 32'(done), 32'd1);
    check("mm_err",  32'(err),  32'd1);
    repeat (3) step();
    check("mm_hold", 32'(cpu_hold), 32'd1);
    corrupt = 0;

    // bad len
    w0 = n_wr; src_n = 4; vmode = 0;
    do_start(0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_err",  32'(err),  32'd1);
    check("len0_ready", 32'(in_ready), 32'd0);
    repeat (2) step();
    do_start(33);
    check("len33_done", 32'(done), 32'd1);
    check("len33_err",  32'(err),  32'd1);
    repeat (2) step();
    check("len33_ready", 32'(in_ready), 32'd0);
    check("badlen_no_write", 32'(n_wr - w0), 32'd0);

    // full depth
    set_words(40); vmode = 0; w0 = n_wr;
    do_start(32);
    wait_done(200);
    check("full_taken",   32'(idx), 32'd32);
    check("full_writes",  32'(n_wr - w0), 32'd32);
    check("full_latency", 32'(cyc - last_acc), 32'd35);
    check("full_mem31",   32'(mem[31]), 32'(src[31]));
    check("full_err",     32'(err), 32'd0);

    // reset mid-load
    set_words(5); vmode = 0; a0 = n_acc;
    do_start(5);
    for (int i = 0; i < 20 && (n_acc - a0) < 2; i++) step();
    rst = 1;
    step();
    check("mrst_in_ready", 32'(in_ready), 32'd0);
    check("mrst_mem_en",   32'(mem_en),   32'd0);
    check("mrst_mem_add",  32'(mem_add),  32'd0);
    check("mrst_datain",   32'(mem_datain), 32'd0);
    check("mrst_hold",     32'(cpu_hold), 32'd1);
    check("mrst_busy",     32'(busy),     32'd0);
    check("mrst_done",     32'(done),     32'd0);
    check("mrst_checksum", 32'(checksum), 32'd0);
    rst = 0;
    step();

    // start during LOAD is ignored
    set_words(8); vmode = 0; a0 = n_acc;
    do_start(4);
    step();
    start = 1; len = 6'd2;
    step();
    start = 0;
    wait_done(100);
    check("midstart_accepts", 32'(n_acc - a0), 32'd4);
    check("midstart_err", 32'(err), 32'd0);

    // start from DONE clears checksum
    cs_prev = checksum;
    set_words(2); vmode = 0;
    do_start(2);
    check("restart_checksum", 32'(checksum), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    wait_done(100);
    check("restart_sum", 32'(checksum), 32'(14'(src[0] + src[1])));
    if (cs_prev == checksum) $display("note: restart checksum equals previous");

    // randomized loads
    for (int r = 0; r < 14; r++) begin
      int lr;
      lr = $urandom_range(1, 32);
      if ($urandom_range(0, 7) == 0) lr = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 63);
      set_words($urandom_range(lr, lr + 3));
      vmode = 2;
      corrupt = ($urandom_range(0, 3) == 0);
      do_start(lr);
      wait_done(300);
      repeat ($urandom_range(0, 3)) step();
    end
    corrupt = 0;

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
